// File: rtl/ad_capture_ctrl.sv
// ============================================================================
//  Module   : ad_capture_ctrl
//  Brief    : Triggered AD acquisition controller that decimates the sample
//             stream, detects a level/slope trigger and fills one frame RAM
//             frame, handing it to the display with a done/ack handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ad_capture_ctrl #(
    parameter int DEPTH   = 480,
    parameter int ADDR_W  = 9,
    parameter int AUTO_TO = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        ad_data,
    input  logic              ad_valid,
    input  logic              run,
    input  logic [1:0]        trig_mode,
    input  logic              trig_slope,
    input  logic [7:0]        trig_level,
    input  logic [15:0]       decim,
    input  logic              frame_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              trig_real,
    output logic              busy
);

    localparam int                TO_W        = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;
    localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(AUTO_TO - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        MODE_AUTO   = 2'b00;
    localparam logic [1:0]        MODE_SINGLE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                run_dly_q, run_dly_d;
    logic [1:0]          mode_q, mode_d;
    logic                slope_q, slope_d;
    logic [7:0]          level_q, level_d;
    logic [15:0]         decim_q, decim_d;
    logic [15:0]         dcnt_q, dcnt_d;
    logic [7:0]          prev_q, prev_d;
    logic                prev_ok_q, prev_ok_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                to_hit_q, to_hit_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                frame_done_q, frame_done_d;
    logic                trig_real_q, trig_real_d;
    logic                busy_q, busy_d;

    logic                in_acq;
    logic                taken;
    logic                trig_hit;
    logic                enter_wait;
    logic                wr_now;
    logic [ADDR_W-1:0]   wr_target;

    assign in_acq   = (state_q == S_WAIT) || (state_q == S_CAPT);
    assign taken    = ad_valid && in_acq && (dcnt_q == 16'd0);
    assign trig_hit = prev_ok_q && (slope_q ? ((prev_q > level_q) && (ad_data <= level_q))
                                            : ((prev_q < level_q) && (ad_data >= level_q)));
    // The trigger sample always lands at address 0; later samples follow ptr_q.
    assign wr_target = (state_q == S_WAIT) ? '0 : ptr_q;

    always_comb begin
        state_d      = state_q;
        run_dly_d    = run;
        mode_d       = mode_q;
        slope_d      = slope_q;
        level_d      = level_q;
        decim_d      = decim_q;
        dcnt_d       = dcnt_q;
        prev_d       = prev_q;
        prev_ok_d    = prev_ok_q;
        to_cnt_d     = to_cnt_q;
        to_hit_d     = to_hit_q;
        ptr_d        = ptr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = frame_done_q;
        trig_real_d  = trig_real_q;
        enter_wait   = 1'b0;
        wr_now       = 1'b0;

        if (ad_valid && in_acq) begin
            dcnt_d = (dcnt_q == decim_q) ? 16'd0 : dcnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (run && ((trig_mode != MODE_SINGLE) || !run_dly_q)) begin
                    enter_wait = 1'b1;
                end
            end
            S_WAIT: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else begin
                    if ((mode_q == MODE_AUTO) && !to_hit_q) begin
                        if (to_cnt_q == TO_LAST) begin
                            to_hit_d    = 1'b1;
                            trig_real_d = 1'b0;
                        end else begin
                            to_cnt_d = to_cnt_q + TO_W'(1);
                        end
                    end
                    // A real trigger overrides a coincident timeout.
                    if (taken) begin
                        if (trig_hit) begin
                            wr_now      = 1'b1;
                            trig_real_d = 1'b1;
                        end else if (to_hit_q) begin
                            wr_now = 1'b1;
                        end else begin
                            prev_d    = ad_data;
                            prev_ok_d = 1'b1;
                        end
                    end
                end
            end
            S_CAPT: begin
                if (taken) begin
                    wr_now = 1'b1;
                end
            end
            S_HOLD: begin
                if (frame_ack) begin
                    frame_done_d = 1'b0;
                    if ((mode_q == MODE_SINGLE) || !run) begin
                        state_d = S_IDLE;
                    end else begin
                        enter_wait = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_now) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_target;
            wr_data_d = ad_data;
            if (wr_target == LAST_ADDR) begin
                state_d      = S_HOLD;
                frame_done_d = 1'b1;
            end else begin
                state_d = S_CAPT;
                ptr_d   = wr_target + ADDR_W'(1);
            end
        end

        if (enter_wait) begin
            state_d   = S_WAIT;
            mode_d    = trig_mode;
            slope_d   = trig_slope;
            level_d   = trig_level;
            decim_d   = decim;
            dcnt_d    = 16'd0;
            prev_ok_d = 1'b0;
            to_cnt_d  = '0;
            to_hit_d  = 1'b0;
        end

        busy_d = (state_d == S_WAIT) || (state_d == S_CAPT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            run_dly_q    <= 1'b0;
            mode_q       <= 2'b00;
            slope_q      <= 1'b0;
            level_q      <= 8'd0;
            decim_q      <= 16'd0;
            dcnt_q       <= 16'd0;
            prev_q       <= 8'd0;
            prev_ok_q    <= 1'b0;
            to_cnt_q     <= '0;
            to_hit_q     <= 1'b0;
            ptr_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'd0;
            frame_done_q <= 1'b0;
            trig_real_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_dly_q    <= run_dly_d;
            mode_q       <= mode_d;
            slope_q      <= slope_d;
            level_q      <= level_d;
            decim_q      <= decim_d;
            dcnt_q       <= dcnt_d;
            prev_q       <= prev_d;
            prev_ok_q    <= prev_ok_d;
            to_cnt_q     <= to_cnt_d;
            to_hit_q     <= to_hit_d;
            ptr_q        <= ptr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            trig_real_q  <= trig_real_d;
            busy_q       <= busy_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign trig_real  = trig_real_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ad_capture_ctrl.sv
// ============================================================================
//  Module   : tb_ad_capture_ctrl
//  Brief    : Directed self-checking bench for ad_capture_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ad_capture_ctrl;

    localparam int DEPTH   = 480;
    localparam int ADDR_W  = 9;
    localparam int AUTO_TO = 1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        ad_data = 8'd0;
    logic              ad_valid = 1'b1;
    logic              run = 1'b0;
    logic [1:0]        trig_mode = 2'b01;
    logic              trig_slope = 1'b0;
    logic [7:0]        trig_level = 8'd100;
    logic [15:0]       decim = 16'd0;
    logic              frame_ack = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_done;
    logic              trig_real;
    logic              busy;

    int total = 0;
    int bad   = 0;
    bit gen_ramp = 1'b1;

    ad_capture_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .AUTO_TO(AUTO_TO)) dut (
        .clk(clk), .rst(rst), .ad_data(ad_data), .ad_valid(ad_valid), .run(run),
        .trig_mode(trig_mode), .trig_slope(trig_slope), .trig_level(trig_level),
        .decim(decim), .frame_ack(frame_ack), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_done(frame_done), .trig_real(trig_real), .busy(busy)
    );

    always #5 clk = ~clk;

    // Outputs are observed 1 time unit after the edge; the ramp advances then too.
    task automatic tick();
        @(posedge clk);
        #1;
        if (gen_ramp) ad_data = ad_data + 8'd1;
    endtask

    task automatic wait_wr(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (wr_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_addr(input int addr, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (wr_en === 1'b1 && wr_addr === ADDR_W'(addr)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; frame_ack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1;
        repeat (3) tick();
        total++;
        if ({wr_en, wr_addr, wr_data, frame_done, trig_real, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got en=%0b addr=%0d data=%0d done=%0b real=%0b busy=%0b want all 0",
                     wr_en, wr_addr, wr_data, frame_done, trig_real, busy);
        end
        rst = 1'b0; run = 1'b0;
        repeat (5) tick();
        total++;
        if (busy !== 1'b0 || wr_en !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet: got busy=%0b en=%0b want 0 0", busy, wr_en);
        end
    endtask

    // Ramp, level 100 rising, normal: frame holds 100..255,0..67; then chained auto frame.
    task automatic test_ramp_and_auto();
        bit ok;
        int errs;
        int n;
        logic tr999, tr1000;
        do_reset();
        gen_ramp = 1'b1; trig_mode = 2'b01; trig_slope = 1'b0; trig_level = 8'd100; decim = 16'd0;
        run = 1'b1;
        wait_wr(600, ok);
        total++;
        if (!ok || wr_addr !== 9'd0 || wr_data !== 8'd100 || trig_real !== 1'b1) begin
            bad++;
            $display("FAIL ramp_first_write: got ok=%0b addr=%0d data=%0d real=%0b want 1 0 100 1",
                     ok, wr_addr, wr_data, trig_real);
        end
        errs = 0;
        for (int k = 1; k < DEPTH; k++) begin
            tick();
            if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(k) || wr_data !== 8'(100 + k)) errs++;
            if (k < DEPTH - 1 && frame_done !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL ramp_frame_sequence: got %0d bad cycles want 0", errs);
        end
        total++;
        if (wr_addr !== 9'd479 || wr_data !== 8'd67 || frame_done !== 1'b1 || trig_real !== 1'b1) begin
            bad++;
            $display("FAIL ramp_last_write: got addr=%0d data=%0d done=%0b real=%0b want 479 67 1 1",
                     wr_addr, wr_data, frame_done, trig_real);
        end
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (wr_en !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL hold_state: got %0d bad cycles want 0", errs);
        end

        // Ack into WAIT_TRIG with auto mode and constant 50 latched.
        gen_ramp = 1'b0; ad_data = 8'd50; trig_mode = 2'b00;
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        total++;
        if (frame_done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ack_to_wait: got done=%0b busy=%0b want 0 1", frame_done, busy);
        end
        n = -1; tr999 = 1'bx; tr1000 = 1'bx;
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (i == 999)  tr999  = trig_real;
            if (i == 1000) tr1000 = trig_real;
            if (wr_en === 1'b1) begin
                n = i;
                break;
            end
        end
        // 1000 cycles in WAIT_TRIG (observations 0..999), strobe in cycle 1000, write next.
        total++;
        if (n != 1001) begin
            bad++;
            $display("FAIL auto_latency: got write at cycle %0d want 1001", n);
        end
        total++;
        if (tr999 !== 1'b1 || tr1000 !== 1'b0) begin
            bad++;
            $display("FAIL auto_trig_real_edge: got %0b,%0b want 1,0", tr999, tr1000);
        end
        total++;
        if (wr_addr !== 9'd0 || wr_data !== 8'd50 || trig_real !== 1'b0) begin
            bad++;
            $display("FAIL auto_first_write: got addr=%0d data=%0d real=%0b want 0 50 0",
                     wr_addr, wr_data, trig_real);
        end
    endtask

    task automatic test_decim();
        bit ok;
        int gap;
        logic [7:0] last;
        do_reset();
        gen_ramp = 1'b1; trig_mode = 2'b01; trig_slope = 1'b0; trig_level = 8'd100; decim = 16'd3;
        run = 1'b1;
        wait_wr(2000, ok);
        total++;
        if (!ok || wr_addr !== 9'd0 || wr_data < 8'd100 || wr_data > 8'd103) begin
            bad++;
            $display("FAIL decim_first_write: got ok=%0b addr=%0d data=%0d want 1 0 100..103",
                     ok, wr_addr, wr_data);
        end
        last = wr_data;
        for (int j = 1; j <= 3; j++) begin
            gap = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                gap++;
                if (wr_en === 1'b1) break;
            end
            total++;
            if (gap != 4 || wr_en !== 1'b1 || wr_addr !== ADDR_W'(j) || wr_data !== 8'(last + 8'd4)) begin
                bad++;
                $display("FAIL decim_spacing_%0d: got gap=%0d addr=%0d data=%0d want 4 %0d %0d",
                         j, gap, wr_addr, wr_data, j, 8'(last + 8'd4));
            end
            last = wr_data;
        end
    endtask

    // Rising ramp only drops through level 100 at the 255 -> 0 wrap.
    task automatic test_falling();
        bit ok;
        do_reset();
        gen_ramp = 1'b1; trig_mode = 2'b11; trig_slope = 1'b1; trig_level = 8'd100; decim = 16'd0;
        run = 1'b1;
        wait_wr(600, ok);
        total++;
        if (!ok || wr_addr !== 9'd0 || wr_data !== 8'd0 || trig_real !== 1'b1) begin
            bad++;
            $display("FAIL falling_trigger: got ok=%0b addr=%0d data=%0d real=%0b want 1 0 0 1",
                     ok, wr_addr, wr_data, trig_real);
        end
        trig_slope = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        int errs;
        do_reset();
        gen_ramp = 1'b1; trig_mode = 2'b10; trig_slope = 1'b0; trig_level = 8'd100; decim = 16'd0;
        run = 1'b1;
        wait_wr(600, ok);
        total++;
        if (!ok || wr_addr !== 9'd0 || wr_data !== 8'd100) begin
            bad++;
            $display("FAIL single_frame1: got ok=%0b addr=%0d data=%0d want 1 0 100", ok, wr_addr, wr_data);
        end
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_done: got frame_done=%0b want 1", frame_done);
        end
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            if (wr_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL single_stays_idle: got %0d bad cycles want 0", errs);
        end
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL single_rearm: got busy=%0b want 1", busy);
        end
        wait_wr(600, ok);
        total++;
        if (!ok || wr_addr !== 9'd0 || wr_data !== 8'd100) begin
            bad++;
            $display("FAIL single_frame2: got ok=%0b addr=%0d data=%0d want 1 0 100", ok, wr_addr, wr_data);
        end
    endtask

    task automatic test_run_drop();
        bit ok;
        int w;
        int errs;
        logic [ADDR_W-1:0] last_addr;
        do_reset();
        gen_ramp = 1'b1; trig_mode = 2'b01; trig_slope = 1'b0; trig_level = 8'd100; decim = 16'd0;
        run = 1'b1;
        wait_addr(200, 800, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rundrop_reach200: got ok=%0b want 1", ok);
        end
        run = 1'b0;
        w = 0; last_addr = '0; ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (wr_en === 1'b1) begin
                w++;
                last_addr = wr_addr;
            end
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok || w != 279 || last_addr !== 9'd479) begin
            bad++;
            $display("FAIL rundrop_completes: got done=%0b writes=%0d last=%0d want 1 279 479", ok, w, last_addr);
        end
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            if (wr_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL rundrop_idle: got %0d bad cycles want 0", errs);
        end
        run = 1'b1;
        tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL rundrop_restart: got busy=%0b want 1", busy);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int errs;
        do_reset();
        gen_ramp = 1'b1; trig_mode = 2'b01; trig_slope = 1'b0; trig_level = 8'd100; decim = 16'd0;
        run = 1'b1;
        wait_addr(100, 800, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rst_reach100: got ok=%0b want 1", ok);
        end
        rst = 1'b1; run = 1'b0;
        tick();
        total++;
        if ({wr_en, wr_addr, wr_data, frame_done, trig_real, busy} !== '0) begin
            bad++;
            $display("FAIL rst_midframe: got en=%0b addr=%0d data=%0d done=%0b real=%0b busy=%0b want all 0",
                     wr_en, wr_addr, wr_data, frame_done, trig_real, busy);
        end
        rst = 1'b0;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (wr_en !== 1'b0 || busy !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL rst_no_writes: got %0d bad cycles want 0", errs);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_and_auto();
        test_decim();
        test_falling();
        test_single();
        test_run_drop();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
